// File: rtl/l2_cache_if.sv
// Request, response, bus and statistics bundle of the L2 tag/state controller.
// The controller takes the slave view; the requester/bus agent takes the master view.
interface l2_cache_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic              resp_hit;
  logic              resp_err;
  logic [1:0]        resp_snoop;
  logic              bus_valid;
  logic [2:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_ready;
  logic [1:0]        bus_snoop_in;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  read_count;
  logic [CNT_W-1:0]  write_count;
  logic              busy;

  modport master (
    output req_valid, req_cmd, req_addr, bus_ready, bus_snoop_in,
    input  req_ready, resp_valid, resp_hit, resp_err, resp_snoop,
    input  bus_valid, bus_op, bus_addr, hit_count, read_count, write_count, busy
  );

  modport slave (
    input  req_valid, req_cmd, req_addr, bus_ready, bus_snoop_in,
    output req_ready, resp_valid, resp_hit, resp_err, resp_snoop,
    output bus_valid, bus_op, bus_addr, hit_count, read_count, write_count, busy
  );
endinterface

// File: rtl/l2_cache_ctrl.sv
// N-way set-associative L2 tag/state controller: MESI coherence, true-LRU ages,
// valid/ready command port, valid/ready bus port and saturating statistics.
module l2_cache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 6,
  parameter int INDEX_W  = 4,
  parameter int WAYS     = 8,
  parameter int CNT_W    = 32
) (
  input logic       clk,
  input logic       rst,
  l2_cache_if.slave bif
);
  localparam int SETS   = 1 << INDEX_W;
  localparam int LINE_W = ADDR_W - OFFSET_W;
  localparam int TAG_W  = LINE_W - INDEX_W;
  localparam int AGE_W  = $clog2(WAYS);

  localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;
  localparam logic [1:0] SNP_HIT = 2'b00, SNP_HITM = 2'b01, SNP_NOHIT = 2'b10;
  localparam logic [2:0] OP_READ = 3'd1, OP_WRITE = 3'd2, OP_INV = 3'd3, OP_RWIM = 3'd4;
  localparam logic [3:0] CMD_RD = 4'd0, CMD_WR = 4'd1, CMD_IRD = 4'd2, CMD_SINV = 4'd3,
                         CMD_SRD = 4'd4, CMD_SWR = 4'd5, CMD_SRFO = 4'd6,
                         CMD_CLR = 4'd8, CMD_PRN = 4'd9;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, BUSOP, CLEAR, RESP} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t             state_r, state_n;
  logic [3:0]         cmd_r, cmd_n;
  logic [LINE_W-1:0]  addr_r, addr_n;
  logic [AGE_W-1:0]   way_r, way_n;
  logic               hit_r, hit_n;
  logic               err_r, err_n;
  logic [1:0]         snoop_r, snoop_n;
  logic [INDEX_W-1:0] clr_idx_r, clr_idx_n;
  logic               bus_valid_r, bus_valid_n;
  logic [2:0]         bus_op_r, bus_op_n;
  logic [ADDR_W-1:0]  bus_addr_r, bus_addr_n;
  logic               resp_valid_r, resp_hit_r, resp_err_r;
  logic [1:0]         resp_snoop_r;
  logic               req_ready_r, busy_r;
  logic [CNT_W-1:0]   hit_cnt_r, read_cnt_r, write_cnt_r;

  logic [TAG_W-1:0]   tag_r  [SETS][WAYS];
  logic [1:0]         mesi_r [SETS][WAYS];
  logic [AGE_W-1:0]   age_r  [SETS][WAYS];

  logic [INDEX_W-1:0] idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic [WAYS-1:0]    match_s, inv_s, old_s;
  logic               hit_s;
  logic [AGE_W-1:0]   hit_way_s, inv_way_s, old_way_s, vict_way_s;
  logic [ADDR_W-1:0]  line_addr_s, vict_addr_s;
  logic [2:0]         fill_op_s;
  logic [AGE_W-1:0]   old_age_s;
  logic               upd_st_s, upd_tag_s, touch_s;
  logic [AGE_W-1:0]   upd_way_s;
  logic [1:0]         new_st_s;
  logic               inc_rd_s, inc_wr_s, inc_hit_s;

  assign idx_s       = addr_r[INDEX_W-1:0];
  assign tag_s       = addr_r[LINE_W-1:INDEX_W];
  assign line_addr_s = {addr_r, OFFSET_W'(0)};
  assign vict_addr_s = {tag_r[idx_s][vict_way_s], idx_s, OFFSET_W'(0)};
  assign fill_op_s   = (cmd_r == CMD_WR) ? OP_RWIM : OP_READ;
  assign old_age_s   = age_r[idx_s][upd_way_s];

  // Tag match and victim choice for the latched set; lowest index wins each search.
  always_comb begin
    match_s   = '0;
    inv_s     = '0;
    old_s     = '0;
    hit_way_s = '0;
    inv_way_s = '0;
    old_way_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      match_s[w] = (mesi_r[idx_s][w] != ST_I) && (tag_r[idx_s][w] == tag_s);
      inv_s[w]   = (mesi_r[idx_s][w] == ST_I);
      old_s[w]   = (age_r[idx_s][w] == AGE_W'(WAYS - 1));
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      hit_way_s = match_s[w] ? AGE_W'(w) : hit_way_s;
      inv_way_s = inv_s[w]   ? AGE_W'(w) : inv_way_s;
      old_way_s = old_s[w]   ? AGE_W'(w) : old_way_s;
    end
    hit_s      = |match_s;
    vict_way_s = (|inv_s) ? inv_way_s : old_way_s;
  end

  // Next-state, bus request and array/counter update decode.
  always_comb begin
    state_n     = state_r;
    cmd_n       = cmd_r;
    addr_n      = addr_r;
    way_n       = way_r;
    hit_n       = hit_r;
    err_n       = err_r;
    snoop_n     = snoop_r;
    clr_idx_n   = clr_idx_r;
    bus_valid_n = bus_valid_r;
    bus_op_n    = bus_op_r;
    bus_addr_n  = bus_addr_r;
    upd_st_s    = 1'b0;
    upd_tag_s   = 1'b0;
    touch_s     = 1'b0;
    upd_way_s   = way_r;
    new_st_s    = ST_I;
    inc_rd_s    = 1'b0;
    inc_wr_s    = 1'b0;
    inc_hit_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bif.req_valid) begin
          cmd_n     = bif.req_cmd;
          addr_n    = bif.req_addr[ADDR_W-1:OFFSET_W];
          hit_n     = 1'b0;
          err_n     = 1'b0;
          snoop_n   = SNP_NOHIT;
          clr_idx_n = '0;
          case (bif.req_cmd)
            CMD_CLR: state_n = CLEAR;
            CMD_PRN: state_n = RESP;
            CMD_RD, CMD_WR, CMD_IRD, CMD_SINV, CMD_SRD, CMD_SWR, CMD_SRFO: state_n = LOOKUP;
            default: begin
              err_n   = 1'b1;
              state_n = RESP;
            end
          endcase
        end else begin
          state_n = IDLE;
        end
      end
      LOOKUP: begin
        hit_n     = hit_s;
        way_n     = hit_s ? hit_way_s : vict_way_s;
        upd_way_s = hit_way_s;
        state_n   = RESP;
        case (cmd_r)
          CMD_RD, CMD_IRD, CMD_WR: begin
            inc_rd_s  = (cmd_r != CMD_WR);
            inc_wr_s  = (cmd_r == CMD_WR);
            inc_hit_s = hit_s;
            touch_s   = hit_s;
            if (hit_s) begin
              // Write hits on S must invalidate the other copies first.
              if ((cmd_r == CMD_WR) && (mesi_r[idx_s][hit_way_s] == ST_S)) begin
                bus_valid_n = 1'b1;
                bus_op_n    = OP_INV;
                bus_addr_n  = line_addr_s;
                state_n     = BUSOP;
              end else begin
                upd_st_s = (cmd_r == CMD_WR);
                new_st_s = ST_M;
              end
            end else if (mesi_r[idx_s][vict_way_s] == ST_M) begin
              bus_valid_n = 1'b1;
              bus_op_n    = OP_WRITE;
              bus_addr_n  = vict_addr_s;
              state_n     = WB;
            end else begin
              bus_valid_n = 1'b1;
              bus_op_n    = fill_op_s;
              bus_addr_n  = line_addr_s;
              state_n     = BUSOP;
            end
          end
          CMD_SRD, CMD_SRFO: begin
            if (!hit_s) begin
              snoop_n = SNP_NOHIT;
            end else if (mesi_r[idx_s][hit_way_s] == ST_M) begin
              snoop_n     = SNP_HITM;
              bus_valid_n = 1'b1;
              bus_op_n    = OP_WRITE;
              bus_addr_n  = line_addr_s;
              state_n     = WB;
            end else begin
              snoop_n  = SNP_HIT;
              upd_st_s = 1'b1;
              new_st_s = (cmd_r == CMD_SRD) ? ST_S : ST_I;
            end
          end
          CMD_SINV: begin
            snoop_n  = SNP_NOHIT;
            upd_st_s = hit_s && (mesi_r[idx_s][hit_way_s] == ST_S);
            new_st_s = ST_I;
          end
          default: snoop_n = SNP_NOHIT;
        endcase
      end
      WB: begin
        if (bif.bus_ready) begin
          if ((cmd_r == CMD_SRD) || (cmd_r == CMD_SRFO)) begin
            bus_valid_n = 1'b0;
            upd_st_s    = 1'b1;
            new_st_s    = (cmd_r == CMD_SRD) ? ST_S : ST_I;
            state_n     = RESP;
          end else begin
            bus_valid_n = 1'b1;
            bus_op_n    = fill_op_s;
            bus_addr_n  = line_addr_s;
            state_n     = BUSOP;
          end
        end else begin
          state_n = WB;
        end
      end
      BUSOP: begin
        if (bif.bus_ready) begin
          bus_valid_n = 1'b0;
          upd_st_s    = 1'b1;
          upd_tag_s   = (bus_op_r != OP_INV);
          touch_s     = (bus_op_r != OP_INV);
          if (bus_op_r == OP_READ) begin
            new_st_s = (bif.bus_snoop_in == SNP_NOHIT) ? ST_E : ST_S;
          end else begin
            new_st_s = ST_M;
          end
          state_n = RESP;
        end else begin
          state_n = BUSOP;
        end
      end
      CLEAR: begin
        clr_idx_n = clr_idx_r + INDEX_W'(1);
        if (clr_idx_r == INDEX_W'(SETS - 1)) begin
          state_n = RESP;
        end else begin
          state_n = CLEAR;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control state plus registered port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cmd_r        <= '0;
      addr_r       <= '0;
      way_r        <= '0;
      hit_r        <= 1'b0;
      err_r        <= 1'b0;
      snoop_r      <= '0;
      clr_idx_r    <= '0;
      bus_valid_r  <= 1'b0;
      bus_op_r     <= '0;
      bus_addr_r   <= '0;
      resp_valid_r <= 1'b0;
      resp_hit_r   <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_snoop_r <= '0;
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_n;
      cmd_r        <= cmd_n;
      addr_r       <= addr_n;
      way_r        <= way_n;
      hit_r        <= hit_n;
      err_r        <= err_n;
      snoop_r      <= snoop_n;
      clr_idx_r    <= clr_idx_n;
      bus_valid_r  <= bus_valid_n;
      bus_op_r     <= bus_op_n;
      bus_addr_r   <= bus_addr_n;
      resp_valid_r <= (state_n == RESP);
      resp_hit_r   <= (state_n == RESP) && hit_n;
      resp_err_r   <= (state_n == RESP) && err_n;
      resp_snoop_r <= (state_n == RESP) ? snoop_n : 2'b00;
      req_ready_r  <= (state_n == IDLE);
      busy_r       <= (state_n != IDLE);
    end
  end

  // Saturating statistics; clear zeroes them while sweeping the sets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_r   <= '0;
      read_cnt_r  <= '0;
      write_cnt_r <= '0;
    end else if (state_r == CLEAR) begin
      hit_cnt_r   <= '0;
      read_cnt_r  <= '0;
      write_cnt_r <= '0;
    end else begin
      if (inc_hit_s) hit_cnt_r   <= sat_inc(hit_cnt_r);
      if (inc_rd_s)  read_cnt_r  <= sat_inc(read_cnt_r);
      if (inc_wr_s)  write_cnt_r <= sat_inc(write_cnt_r);
    end
  end

  // Tag, MESI and LRU-age arrays; clear resets one set per cycle, dirty lines dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          tag_r[s][w]  <= '0;
          mesi_r[s][w] <= ST_I;
          age_r[s][w]  <= AGE_W'(w);
        end
      end
    end else if (state_r == CLEAR) begin
      for (int w = 0; w < WAYS; w++) begin
        mesi_r[clr_idx_r][w] <= ST_I;
        age_r[clr_idx_r][w]  <= AGE_W'(w);
      end
    end else begin
      if (upd_st_s)  mesi_r[idx_s][upd_way_s] <= new_st_s;
      if (upd_tag_s) tag_r[idx_s][upd_way_s]  <= tag_s;
      if (touch_s) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == upd_way_s) begin
            age_r[idx_s][w] <= '0;
          end else if (age_r[idx_s][w] < old_age_s) begin
            age_r[idx_s][w] <= age_r[idx_s][w] + AGE_W'(1);
          end
        end
      end
    end
  end

  assign bif.req_ready   = req_ready_r;
  assign bif.resp_valid  = resp_valid_r;
  assign bif.resp_hit    = resp_hit_r;
  assign bif.resp_err    = resp_err_r;
  assign bif.resp_snoop  = resp_snoop_r;
  assign bif.bus_valid   = bus_valid_r;
  assign bif.bus_op      = bus_op_r;
  assign bif.bus_addr    = bus_addr_r;
  assign bif.hit_count   = hit_cnt_r;
  assign bif.read_count  = read_cnt_r;
  assign bif.write_count = write_cnt_r;
  assign bif.busy        = busy_r;
endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Directed bench for l2_cache_ctrl: issues commands, acts as bus agent, and
// compares responses, bus traffic and statistics against hand-derived values.
module tb_l2_cache_ctrl;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  l2_cache_if #(.ADDR_W(32), .CNT_W(32)) bif ();

  l2_cache_ctrl #(
    .ADDR_W(32), .OFFSET_W(6), .INDEX_W(4), .WAYS(8), .CNT_W(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  ops   [8];
  logic [31:0] addrs [8];
  int          nops, stab_err, busy_cnt, rdy_cnt, r_lat;
  logic        got_resp, r_hit, r_err;
  logic [1:0]  r_snoop;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command, serve its bus ops (ready after wait_n cycles), capture the response.
  task automatic run(input string nm, input logic [3:0] cmd, input logic [31:0] addr,
                     input logic [1:0] snp, input int wait_n);
    int held;
    int guard;
    nops = 0; stab_err = 0; busy_cnt = 0; rdy_cnt = 0; r_lat = 0;
    got_resp = 1'b0; r_hit = 1'b0; r_err = 1'b0; r_snoop = 2'b00;
    held = 0; guard = 0;
    @(negedge clk);
    while (!bif.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bif.req_valid = 1'b1;
    bif.req_cmd   = cmd;
    bif.req_addr  = addr;
    @(negedge clk);
    bif.req_valid = 1'b0;
    for (int lat = 1; lat <= 200 && !got_resp; lat++) begin
      if (bif.resp_valid) begin
        got_resp = 1'b1;
        r_lat    = lat;
        r_hit    = bif.resp_hit;
        r_err    = bif.resp_err;
        r_snoop  = bif.resp_snoop;
      end else begin
        busy_cnt += int'(bif.busy);
        rdy_cnt  += int'(bif.req_ready);
        if (bif.bus_valid) begin
          if (held == 0) begin
            if (nops < 8) begin
              ops[nops]   = bif.bus_op;
              addrs[nops] = bif.bus_addr;
            end
            nops++;
          end else if (nops <= 8 && (bif.bus_op !== ops[nops-1] || bif.bus_addr !== addrs[nops-1])) begin
            stab_err++;
          end
          if (held >= wait_n) begin
            bif.bus_ready    = 1'b1;
            bif.bus_snoop_in = snp;
            held = 0;
          end else begin
            bif.bus_ready = 1'b0;
            held++;
          end
        end else begin
          bif.bus_ready = 1'b0;
        end
        @(negedge clk);
      end
    end
    bif.bus_ready = 1'b0;
    check_val({nm, "_done"}, 64'(got_resp), 64'd1);
  endtask

  initial begin
    int guard;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bif.req_valid    = 1'b0;
    bif.req_cmd      = 4'd0;
    bif.req_addr     = 32'd0;
    bif.bus_ready    = 1'b0;
    bif.bus_snoop_in = 2'b10;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_val("rst_req_ready",  64'(bif.req_ready),  64'd1);
    check_val("rst_bus_valid",  64'(bif.bus_valid),  64'd0);
    check_val("rst_resp_valid", 64'(bif.resp_valid), 64'd0);
    check_val("rst_busy",       64'(bif.busy),       64'd0);
    check_val("rst_read_count", 64'(bif.read_count), 64'd0);

    // Read miss, NOHIT -> E; then a hit two cycles after acceptance.
    run("rd40_miss", 4'd0, 32'h40, 2'b10, 2);
    check_val("rd40_nops", 64'(nops), 64'd1);
    check_val("rd40_op", 64'(ops[0]), 64'd1);
    check_val("rd40_addr", 64'(addrs[0]), 64'h40);
    check_val("rd40_stable", 64'(stab_err), 64'd0);
    check_val("rd40_hit", 64'(r_hit), 64'd0);
    check_val("rd40_rcnt", 64'(bif.read_count), 64'd1);
    run("rd40_hit", 4'd0, 32'h40, 2'b10, 0);
    check_val("rd40h_hit", 64'(r_hit), 64'd1);
    check_val("rd40h_lat", 64'(r_lat), 64'd2);
    check_val("rd40h_nops", 64'(nops), 64'd0);
    check_val("rd40h_hcnt", 64'(bif.hit_count), 64'd1);

    // Read with snoop HIT -> S; write hit on S needs INVALIDATE.
    run("rd80", 4'd0, 32'h80, 2'b00, 0);
    check_val("rd80_op", 64'(ops[0]), 64'd1);
    run("wr80", 4'd1, 32'h80, 2'b10, 0);
    check_val("wr80_nops", 64'(nops), 64'd1);
    check_val("wr80_op", 64'(ops[0]), 64'd3);
    check_val("wr80_addr", 64'(addrs[0]), 64'h80);
    check_val("wr80_hit", 64'(r_hit), 64'd1);
    check_val("wr80_wcnt", 64'(bif.write_count), 64'd1);
    check_val("wr80_hcnt", 64'(bif.hit_count), 64'd2);
    run("srd80", 4'd4, 32'h80, 2'b10, 0);
    check_val("srd80_snoop", 64'(r_snoop), 64'd1);
    check_val("srd80_op", 64'(ops[0]), 64'd2);
    check_val("srd80_addr", 64'(addrs[0]), 64'h80);

    // Write hit on E upgrades silently.
    run("wr40", 4'd1, 32'h40, 2'b10, 0);
    check_val("wr40_nops", 64'(nops), 64'd0);
    check_val("wr40_hit", 64'(r_hit), 64'd1);

    // Fill set 0 with eight dirty lines, then evict the LRU one.
    for (int k = 0; k < 8; k++) begin
      run("fill", 4'd1, 32'(k) * 32'h400, 2'b10, 0);
      check_val("fill_op", 64'(ops[0]), 64'd4);
      check_val("fill_addr", 64'(addrs[0]), 64'(32'(k) * 32'h400));
    end
    run("evict", 4'd1, 32'h2000, 2'b10, 1);
    check_val("evict_nops", 64'(nops), 64'd2);
    check_val("evict_wb_op", 64'(ops[0]), 64'd2);
    check_val("evict_wb_addr", 64'(addrs[0]), 64'h0);
    check_val("evict_fill_op", 64'(ops[1]), 64'd4);
    check_val("evict_fill_addr", 64'(addrs[1]), 64'h2000);
    check_val("evict_stable", 64'(stab_err), 64'd0);
    run("rd400", 4'd0, 32'h400, 2'b10, 0);
    check_val("rd400_hit", 64'(r_hit), 64'd1);
    run("rd000", 4'd0, 32'h0, 2'b10, 0);
    check_val("rd000_nops", 64'(nops), 64'd2);
    check_val("rd000_wb_addr", 64'(addrs[0]), 64'h800);
    check_val("rd000_fill_op", 64'(ops[1]), 64'd1);

    // Snoop sequence on 0x100.
    run("wr100", 4'd1, 32'h100, 2'b10, 0);
    run("srd100", 4'd4, 32'h100, 2'b10, 0);
    check_val("srd100_snoop", 64'(r_snoop), 64'd1);
    check_val("srd100_op", 64'(ops[0]), 64'd2);
    check_val("srd100_addr", 64'(addrs[0]), 64'h100);
    run("srfo100", 4'd6, 32'h100, 2'b10, 0);
    check_val("srfo100_snoop", 64'(r_snoop), 64'd0);
    check_val("srfo100_nops", 64'(nops), 64'd0);
    run("srd100_i", 4'd4, 32'h100, 2'b10, 0);
    check_val("srd100i_snoop", 64'(r_snoop), 64'd2);
    check_val("srd100i_hit", 64'(r_hit), 64'd0);
    run("srd_absent", 4'd4, 32'h12340, 2'b10, 0);
    check_val("srd_absent_snoop", 64'(r_snoop), 64'd2);
    run("rd100", 4'd0, 32'h100, 2'b10, 0);
    check_val("rd100_op", 64'(ops[0]), 64'd1);
    run("srd100_e", 4'd4, 32'h100, 2'b10, 0);
    check_val("srd100e_snoop", 64'(r_snoop), 64'd0);
    check_val("srd100e_nops", 64'(nops), 64'd0);

    // Invalidate on S, snoop write no-op, snoop RFO on M.
    run("sinv80", 4'd3, 32'h80, 2'b10, 0);
    check_val("sinv80_snoop", 64'(r_snoop), 64'd2);
    run("rd80b", 4'd0, 32'h80, 2'b10, 0);
    check_val("rd80b_nops", 64'(nops), 64'd1);
    check_val("rd80b_op", 64'(ops[0]), 64'd1);
    run("swr40", 4'd5, 32'h40, 2'b10, 0);
    check_val("swr40_snoop", 64'(r_snoop), 64'd2);
    check_val("swr40_nops", 64'(nops), 64'd0);
    run("rd40c", 4'd0, 32'h40, 2'b10, 0);
    check_val("rd40c_hit", 64'(r_hit), 64'd1);
    run("srfo40", 4'd6, 32'h40, 2'b10, 0);
    check_val("srfo40_snoop", 64'(r_snoop), 64'd1);
    check_val("srfo40_op", 64'(ops[0]), 64'd2);
    check_val("srfo40_addr", 64'(addrs[0]), 64'h40);

    check_val("cnt_read", 64'(bif.read_count), 64'd8);
    check_val("cnt_write", 64'(bif.write_count), 64'd12);
    check_val("cnt_hit", 64'(bif.hit_count), 64'd5);

    // Print, unsupported code, clear.
    run("print", 4'd9, 32'h0, 2'b10, 0);
    check_val("print_lat", 64'(r_lat), 64'd1);
    check_val("print_err", 64'(r_err), 64'd0);
    check_val("print_rcnt", 64'(bif.read_count), 64'd8);
    run("bad7", 4'd7, 32'h0, 2'b10, 0);
    check_val("bad7_err", 64'(r_err), 64'd1);
    run("clear", 4'd8, 32'h0, 2'b10, 0);
    check_val("clear_lat", 64'(r_lat), 64'd17);
    check_val("clear_busy", 64'(busy_cnt), 64'd16);
    check_val("clear_ready", 64'(rdy_cnt), 64'd0);
    check_val("clear_hcnt", 64'(bif.hit_count), 64'd0);
    check_val("clear_wcnt", 64'(bif.write_count), 64'd0);
    run("rd400c", 4'd0, 32'h400, 2'b10, 0);
    check_val("rd400c_nops", 64'(nops), 64'd1);
    check_val("rd400c_op", 64'(ops[0]), 64'd1);
    check_val("rd400c_rcnt", 64'(bif.read_count), 64'd1);

    // Reset while a bus op is pending.
    @(negedge clk);
    bif.req_valid = 1'b1;
    bif.req_cmd   = 4'd0;
    bif.req_addr  = 32'h5040;
    @(negedge clk);
    bif.req_valid = 1'b0;
    guard = 0;
    while (!bif.bus_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check_val("arst_wait_bus", 64'(bif.bus_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_val("arst_bus_valid", 64'(bif.bus_valid), 64'd0);
    check_val("arst_busy", 64'(bif.busy), 64'd0);
    check_val("arst_req_ready", 64'(bif.req_ready), 64'd1);
    check_val("arst_rcnt", 64'(bif.read_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_val("arst_idle_bus", 64'(bif.bus_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
